// File: rtl/assertion_seq_checker_pkg.sv
// Shared constants for the temporal assertion stage: mode encodings, default
// window depth, counter width and the window-counter width helper.
package assertion_pkg;

    localparam logic [1:0] MODE_NEXT   = 2'd0;
    localparam logic [1:0] MODE_WITHIN = 2'd1;
    localparam logic [1:0] MODE_HOLD   = 2'd2;
    localparam logic [1:0] MODE_RSVD   = 2'd3;

    localparam int DEFAULT_MAX_CKS = 7;
    localparam int CNT_W           = 8;

    function automatic int ck_width(input int max_cks);
        return $clog2(max_cks + 1);
    endfunction

endpackage

// File: rtl/assertion_seq_checker_if.sv
// Bundle of the assertion stage's fabric-side signals; the violCount field
// exists only when ASSERT_VIOL_COUNT_EN is defined.
interface assertion_seq_checker_if #(
    parameter int NUM_CH = 5,
    parameter int CK_W   = 3
);
    logic                   enable;
    logic                   clear;
    logic [NUM_CH-1:0]      trig;
    logic [NUM_CH-1:0]      cond;
    logic [NUM_CH*CK_W-1:0] num_cks;
    logic [NUM_CH*2-1:0]    select;
    logic [NUM_CH-1:0]      res_sel;
    logic [NUM_CH-1:0]      configInvalid;
    logic [NUM_CH-1:0]      assertionsViolated;
    logic                   assertionViolated;
`ifdef ASSERT_VIOL_COUNT_EN
    logic [NUM_CH*8-1:0]    violCount;
`endif

    modport master (
        output enable, clear, trig, cond, num_cks, select, res_sel,
        input  configInvalid, assertionsViolated, assertionViolated
`ifdef ASSERT_VIOL_COUNT_EN
        , input violCount
`endif
    );

    modport slave (
        input  enable, clear, trig, cond, num_cks, select, res_sel,
        output configInvalid, assertionsViolated, assertionViolated
`ifdef ASSERT_VIOL_COUNT_EN
        , output violCount
`endif
    );

endinterface

// File: rtl/assertion_seq_checker_channel.sv
// One assertion channel: frozen config, validity check, NEXT/WITHIN/HOLD
// window logic, sticky flag and (with ASSERT_VIOL_COUNT_EN) a saturating counter.
module assertion_seq_channel
    import assertion_pkg::*;
#(
    parameter int MAX_CKS = DEFAULT_MAX_CKS,
    parameter int CK_W    = ck_width(MAX_CKS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear,
    input  logic             trig,
    input  logic             cond,
    input  logic [CK_W-1:0]  num_cks,
    input  logic [1:0]       select,
    input  logic             res_sel,
    output logic             config_invalid,
    output logic             violated
`ifdef ASSERT_VIOL_COUNT_EN
    ,
    output logic [CNT_W-1:0] viol_count
`endif
);

    logic [CK_W-1:0]    cks_q, cks_d;
    logic [1:0]         sel_q, sel_d;
    logic               inv_q, inv_d;
    logic               invalid_q, invalid_d;
    logic [MAX_CKS-1:0] hist_q, hist_d;
    logic               armed_q, armed_d;
    logic [CK_W-1:0]    cnt_q, cnt_d;
    logic               flag_q, flag_d;

    logic               cfg_bad;
    logic               active;
    logic               ce;
    logic               due;
    logic               viol;
    logic               armed_eff;
    logic [CK_W-1:0]    cnt_eff;
    logic [MAX_CKS:0]   pend;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        cks_d     = enable ? cks_q : num_cks;
        sel_d     = enable ? sel_q : select;
        inv_d     = enable ? inv_q : res_sel;

        cfg_bad   = (sel_q == MODE_RSVD) || (int'(cks_q) > MAX_CKS);
        invalid_d = cfg_bad;
        active    = enable && !cfg_bad;
        ce        = cond ^ inv_q;

        // pend[k] is a trigger seen k cycles ago, bit 0 being this cycle
        pend = {hist_q, trig};
        due  = 1'b0;
        for (int k = 0; k <= MAX_CKS; k++) begin
            if (int'(cks_q) == k) due = pend[k];
        end

        hist_d    = '0;
        armed_d   = 1'b0;
        cnt_d     = '0;
        viol      = 1'b0;
        armed_eff = armed_q;
        cnt_eff   = cnt_q;

        if (active) begin
            case (sel_q)
                MODE_NEXT: begin
                    hist_d = pend[MAX_CKS-1:0];
                    viol   = due && !ce;
                end
                MODE_WITHIN: begin
                    if (!armed_q && trig) begin
                        armed_eff = 1'b1;
                        cnt_eff   = cks_q;
                    end
                    if (armed_eff && !ce) begin
                        if (cnt_eff == '0) begin
                            viol = 1'b1;
                        end else begin
                            armed_d = 1'b1;
                            cnt_d   = cnt_eff - CK_W'(1);
                        end
                    end
                end
                MODE_HOLD: begin
                    if (trig) begin
                        armed_eff = 1'b1;
                        cnt_eff   = cks_q;
                    end
                    if (armed_eff) begin
                        if (!ce) begin
                            viol = 1'b1;
                        end else if (cnt_eff != '0) begin
                            armed_d = 1'b1;
                            cnt_d   = cnt_eff - CK_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end

        // a violation in the clear cycle wins, so the flag stays set
        flag_d = (flag_q && !clear) || viol;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cks_q     <= '0;
            sel_q     <= MODE_NEXT;
            inv_q     <= 1'b0;
            invalid_q <= 1'b0;
            hist_q    <= '0;
            armed_q   <= 1'b0;
            cnt_q     <= '0;
            flag_q    <= 1'b0;
        end else begin
            // NOTE: state flops use non-blocking assignments so all of them update from pre-edge values.
            cks_q     <= cks_d;
            sel_q     <= sel_d;
            inv_q     <= inv_d;
            invalid_q <= invalid_d;
            hist_q    <= hist_d;
            armed_q   <= armed_d;
            cnt_q     <= cnt_d;
            flag_q    <= flag_d;
        end
    end

    assign config_invalid = invalid_q;
    assign violated       = flag_q;

`ifdef ASSERT_VIOL_COUNT_EN
    logic [CNT_W-1:0] vcnt_q, vcnt_d;

    always_comb begin
        vcnt_d = clear ? '0 : vcnt_q;
        if (viol && (vcnt_d != '1)) vcnt_d = vcnt_d + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) vcnt_q <= '0;
        else      vcnt_q <= vcnt_d;
    end

    assign viol_count = vcnt_q;
`endif

endmodule

// File: rtl/assertion_seq_checker.sv
// Temporal assertion stage: NUM_CH independent channels plus the global
// violation OR. Optional per-channel counters under ASSERT_VIOL_COUNT_EN.
module assertion_seq_checker
    import assertion_pkg::*;
#(
    parameter int NUM_CH  = 5,
    parameter int MAX_CKS = DEFAULT_MAX_CKS,
    parameter int CK_W    = ck_width(MAX_CKS)
) (
    input logic                    clk,
    input logic                    rst,
    assertion_seq_checker_if.slave bus
);

    logic [NUM_CH-1:0] inv_vec;
    logic [NUM_CH-1:0] viol_vec;
`ifdef ASSERT_VIOL_COUNT_EN
    logic [NUM_CH*CNT_W-1:0] cnt_vec;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assertion_seq_channel #(
            .MAX_CKS (MAX_CKS),
            .CK_W    (CK_W)
        ) u_ch (
            .clk            (clk),
            .rst            (rst),
            .enable         (bus.enable),
            .clear          (bus.clear),
            .trig           (bus.trig[i]),
            .cond           (bus.cond[i]),
            .num_cks        (bus.num_cks[i*CK_W +: CK_W]),
            .select         (bus.select[i*2 +: 2]),
            .res_sel        (bus.res_sel[i]),
            .config_invalid (inv_vec[i]),
            .violated       (viol_vec[i])
`ifdef ASSERT_VIOL_COUNT_EN
            ,
            .viol_count     (cnt_vec[i*CNT_W +: CNT_W])
`endif
        );
    end

    assign bus.configInvalid      = inv_vec;
    assign bus.assertionsViolated = viol_vec;
    assign bus.assertionViolated  = |viol_vec;
`ifdef ASSERT_VIOL_COUNT_EN
    assign bus.violCount          = cnt_vec;
`endif

endmodule

// File: tb/tb_assertion_seq_checker.sv
// Directed bench for assertion_seq_checker: a per-cycle vector table for the
// mixed-mode run plus hand-written sequences for config, clear and reset corners.
module tb_assertion_seq_checker;

    localparam int NUM_CH = 5;
    localparam int CK_W   = 3;

    typedef struct {
        logic [4:0] trig;
        logic [4:0] cond;
        logic       clear;
        logic [4:0] exp_viol;
    } vec_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    assertion_seq_checker_if #(.NUM_CH(NUM_CH), .CK_W(CK_W)) bus ();
    assertion_seq_checker_if #(.NUM_CH(1), .CK_W(3)) bus_r ();

    assertion_seq_checker #(.NUM_CH(NUM_CH), .MAX_CKS(7), .CK_W(CK_W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assertion_seq_checker #(.NUM_CH(1), .MAX_CKS(5), .CK_W(3)) u_dut_r (
        .clk (clk),
        .rst (rst),
        .bus (bus_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t rows [10];

    initial begin
        n_tests = 0;
        n_fail  = 0;

        // ch0 NEXT n3 | ch1 WITHIN n2 | ch2 HOLD n4 | ch3 reserved | ch4 NEXT n0 inverted
        rows[0] = '{5'b01000, 5'b00101, 1'b0, 5'b00000};
        rows[1] = '{5'b01111, 5'b00101, 1'b0, 5'b00000};
        rows[2] = '{5'b11001, 5'b10101, 1'b0, 5'b10000};
        rows[3] = '{5'b01000, 5'b00011, 1'b0, 5'b10100};
        rows[4] = '{5'b01100, 5'b00100, 1'b1, 5'b00001};
        rows[5] = '{5'b11000, 5'b00101, 1'b0, 5'b00001};
        rows[6] = '{5'b01010, 5'b00101, 1'b0, 5'b00001};
        rows[7] = '{5'b01010, 5'b00101, 1'b0, 5'b00001};
        rows[8] = '{5'b01000, 5'b00101, 1'b0, 5'b00011};
        rows[9] = '{5'b01000, 5'b00101, 1'b0, 5'b00011};

        bus.enable  = 1'b0; bus.clear = 1'b0; bus.trig = '0; bus.cond = '0;
        bus.num_cks = '0;   bus.select = '0;  bus.res_sel = '0;
        bus_r.enable  = 1'b0; bus_r.clear = 1'b0; bus_r.trig = '0; bus_r.cond = '0;
        bus_r.num_cks = '0;   bus_r.select = '0;  bus_r.res_sel = '0;

        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        check("reset_viol",    32'(bus.assertionsViolated), 32'h0);
        check("reset_any",     32'(bus.assertionViolated),  32'h0);
        check("reset_invalid", 32'(bus.configInvalid),      32'h0);
        tick();
        rst = 1'b1;

        // window-length range check on the MAX_CKS=5 instance
        bus_r.num_cks = 3'd5;
        tick(); tick();
        check("range_max_valid", 32'(bus_r.configInvalid), 32'h0);
        bus_r.num_cks = 3'd6;
        tick();
        check("range_lag", 32'(bus_r.configInvalid), 32'h0);
        tick();
        check("range_over_invalid", 32'(bus_r.configInvalid), 32'h1);
        bus_r.enable = 1'b1; bus_r.trig = 1'b1; bus_r.cond = 1'b0;
        repeat (4) tick();
        check("range_no_viol", 32'(bus_r.assertionsViolated), 32'h0);
        bus_r.enable = 1'b0; bus_r.trig = 1'b0;

        // main configuration, captured while enable is low
        bus.num_cks = {3'd0, 3'd0, 3'd4, 3'd2, 3'd3};
        bus.select  = {2'd0, 2'd3, 2'd2, 2'd1, 2'd0};
        bus.res_sel = 5'b10000;
        tick();
        check("cfg_invalid_lag", 32'(bus.configInvalid), 32'h0);
        tick();
        check("cfg_invalid", 32'(bus.configInvalid), 32'h08);

        bus.enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.trig  = rows[i].trig;
            bus.cond  = rows[i].cond;
            bus.clear = rows[i].clear;
            tick();
            check($sformatf("row%0d_viol", i), 32'(bus.assertionsViolated), 32'(rows[i].exp_viol));
            check($sformatf("row%0d_any", i),  32'(bus.assertionViolated),  32'(|rows[i].exp_viol));
        end
        check("cfg_invalid_after_run", 32'(bus.configInvalid), 32'h08);

        // clear with no violation pending drops every flag
        bus.trig = '0; bus.cond = '0; bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        check("clear_alone", 32'(bus.assertionsViolated), 32'h0);

        // enable low aborts an armed WITHIN window
        bus.trig = 5'b00010;
        tick();
        bus.trig = '0; bus.enable = 1'b0;
        tick();
        bus.enable = 1'b1;
        repeat (3) tick();
        check("enable_low_clears_window", 32'(bus.assertionsViolated), 32'h0);

        // config is frozen while enable is high
        bus.select = {2'd0, 2'd0, 2'd2, 2'd1, 2'd3};
        tick(); tick();
        check("cfg_frozen", 32'(bus.configInvalid), 32'h08);

        // ch0 still runs NEXT n3: trig then ce 0 three cycles later
        bus.trig = 5'b00001; bus.cond = '0;
        tick();
        bus.trig = '0;
        repeat (2) tick();
        check("frozen_next_pending", 32'(bus.assertionsViolated), 32'h0);
        tick();
        check("frozen_next_viol", 32'(bus.assertionsViolated), 32'h01);

        // reset in the middle of a HOLD window
        bus.trig = 5'b00100; bus.cond = 5'b00100;
        tick();
        bus.trig = '0;
        tick();
        #2 rst = 1'b0;
        #1;
        check("async_reset_viol",    32'(bus.assertionsViolated), 32'h0);
        check("async_reset_any",     32'(bus.assertionViolated),  32'h0);
        check("async_reset_invalid", 32'(bus.configInvalid),      32'h0);
        tick();
        bus.cond = '0;
        rst = 1'b1;
        repeat (3) tick();
        check("post_reset_quiet", 32'(bus.assertionsViolated), 32'h0);
        check("post_reset_invalid", 32'(bus.configInvalid), 32'h0);

`ifdef ASSERT_VIOL_COUNT_EN
        // reset config is NEXT n0: trig with ce 0 violates every cycle
        bus.trig = 5'b00001; bus.cond = '0;
        repeat (300) tick();
        check("count_saturate", 32'(bus.violCount[7:0]),  32'd255);
        check("count_idle_ch",  32'(bus.violCount[15:8]), 32'd0);
        bus.trig = '0; bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        check("count_clear", 32'(bus.violCount[7:0]), 32'd0);
        check("count_clear_flag", 32'(bus.assertionsViolated), 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
